hwpe_stream_fifo_ctrl_occ: RTL and testbench
============================================

Name: hwpe_stream_fifo_ctrl_occ

Overview:
Parametrised FIFO control engine for HWPE-Stream buffers of arbitrary (non-power-of-2) depth. It drives write/read addressing for an external latch- or flop-based storage array and exposes the "virtual" push/pop handshake to the surrounding stream logic. Compared to the existing FIFO controllers, it adds an explicit occupancy counter, parametrised almost-full/almost-empty thresholds, and an optional empty-bypass (fall-through) mode. It sits between stream sinks/sources and multi-bank buffer datapaths that must move in lockstep.

Parameters:
- FIFO_DEPTH, 8: number of entries; any integer >= 2, not restricted to powers of 2.
- ALMOST_FULL_TH, FIFO_DEPTH-2: almost_full asserts when count >= this value; legal range 1..FIFO_DEPTH.
- ALMOST_EMPTY_TH, 2: almost_empty asserts when count <= this value; legal range 0..FIFO_DEPTH-1.
- Derived (localparam): ADDR_W = max(1, clog2(FIFO_DEPTH)); CNT_W = clog2(FIFO_DEPTH+1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- push_valid_i  in  1  producer has an item.
- push_ready_o  out  1  controller accepts a push this cycle.
- pop_valid_o  out  1  an item is available at rd_addr_o, or on bypass.
- pop_ready_i  in  1  consumer takes the item.
- wr_en_o  out  1  write strobe to storage (= accepted non-bypassed push).
- wr_addr_o  out  ADDR_W  storage write address (= push pointer).
- rd_addr_o  out  ADDR_W  storage read address (= pop pointer).
- bypass_o  out  1  datapath must route push data directly to pop output.
- flags_o  out  flags_fifo_occ_t  empty, full, almost_empty, almost_full, count, push_pointer, pop_pointer.

Behaviour:
- Reset / clear: rst_i is checked first, then clear_i; both are synchronous. Effects:
  - FSM goes to EMPTY; both pointers and count go to 0.
  - Outputs after reset: push_ready_o=1, pop_valid_o=0, wr_en_o=0, bypass_o=0.
  - Flags after reset: empty=1, full=0, almost_empty=1 (count 0 <= TH), almost_full=0.
  - A clear overrides any push or pop in the same cycle. An item in flight during mid-operation clear is dropped.
- FSM states: EMPTY, MIDDLE, FULL, registered.
  - Invariant: EMPTY <=> count==0; FULL <=> count==FIFO_DEPTH.
  - Illegal state encoding: outputs are driven to safe values (ready=0, valid=0) and the next state is EMPTY with pointers and count zeroed.
- Handshake:
  - push_ready_o = (cs != FULL).
  - pop_valid_o = (cs != EMPTY), plus the bypass case below.
  - push_ready_o does not depend on pop_ready_i, so there is no combinational ready path. A push is therefore refused in FULL even when a pop happens in the same cycle.
  - push = push_valid_i & push_ready_o; pop = pop_valid_o & pop_ready_i.
- Storage timing: wr_en_o = push & ~bypass. Data is written at the edge. It is readable at rd_addr_o from the next cycle; push-to-pop latency is 1 cycle.
- Pointers: each increments on its event and wraps FIFO_DEPTH-1 -> 0 explicitly; there is no modulo-2^N arithmetic.
- Counter: count_d = count_q + push - pop, CNT_W bits.
  - Simultaneous push and pop in MIDDLE: count unchanged, both pointers advance.
- Transitions:
  - EMPTY + push -> MIDDLE; with FIFO_DEPTH==1 it goes straight to FULL, but the minimum depth of 2 excludes that case.
  - MIDDLE + push only, count_q==FIFO_DEPTH-1 -> FULL.
  - MIDDLE + pop only, count_q==1 -> EMPTY.
  - FULL + pop -> MIDDLE.
  - All other combinations hold the current state.
- Flags: almost_* are combinational from count_q only, with no glitch path from the inputs. flags_o.count = count_q.
- Elaboration: $error if thresholds are outside their legal ranges or FIFO_DEPTH < 2.

Optional Feature:
- Macro: HWPE_STREAM_FIFO_CTRL_OCC_FALLTHROUGH_EN.
- When defined:
  - In EMPTY with push_valid_i=1: pop_valid_o=1 and bypass_o=1.
  - If pop_ready_i=1 as well: the item passes through; no write, no pointer or count change, state stays EMPTY.
  - If pop_ready_i=0: normal push (wr_en_o=1, bypass_o=0 for the write), going to MIDDLE.
  - Zero-latency path from push_valid_i to pop_valid_o.
- When undefined: bypass_o is tied to 0 and EMPTY never asserts pop_valid_o.

Decomposition:
- In hwpe_stream_package: typedef flags_fifo_occ_t, a packed struct with empty, full, almost_empty, almost_full, count[15:0], push_pointer[15:0], pop_pointer[15:0], sized for max depth 65535.
- The FSM state enum also lives in the package as fifo_ctrl_state_t.
- One natural sub-module: hwpe_stream_wrap_counter (parametrised modulo-N incrementer with enable/clear). It is instantiated twice, once per pointer.

Test Plan:
- Reset then idle, FIFO_DEPTH=5:
  - Response: count=0, empty=1, push_ready_o=1, pop_valid_o=0, almost_empty=1.
  - Assert rst_i mid-fill at count=3 -> next cycle count=0, pointers=0.
- Fill, FIFO_DEPTH=5, no pops: 5 pushes -> wr_addr_o sequence 0,1,2,3,4; full=1 after the 5th; push_ready_o=0; a 6th push_valid_i is ignored with count held at 5.
- Wrap, FIFO_DEPTH=5:
  - Stimulus: 7 pushes interleaved with 7 pops.
  - Response: both pointers go 4 -> 0 -> 1; final count=0, empty=1.
- Simultaneous push/pop at count=3, FIFO_DEPTH=5: 10 cycles of push_valid_i=pop_ready_i=1 -> count stays 3, both pointers advance 10 mod 5.
- Thresholds, ALMOST_FULL_TH=4 and ALMOST_EMPTY_TH=1: ramp count 0..5..0 -> almost_full high exactly at count 4 and 5; almost_empty high exactly at count 0 and 1.
- Fall-through, macro defined, EMPTY:
  - push_valid_i=pop_ready_i=1 -> bypass_o=1, wr_en_o=0, count stays 0.
  - push_valid_i=1 with pop_ready_i=0 -> wr_en_o=1 and count becomes 1.

Source files
------------

// File: rtl/hwpe_stream_fifo_ctrl_occ_pkg.sv
// Shared types and width helpers for the occupancy-tracking FIFO controller.
package hwpe_stream_fifo_ctrl_occ_pkg;

    // Status word, sized for depths up to 65535 entries.
    typedef struct packed {
        logic        empty;
        logic        full;
        logic        almost_empty;
        logic        almost_full;
        logic [15:0] count;
        logic [15:0] push_pointer;
        logic [15:0] pop_pointer;
    } flags_fifo_occ_t;

    // state  | meaning
    // EMPTY  | count == 0, nothing to pop (except fall-through)
    // MIDDLE | 0 < count < FIFO_DEPTH
    // FULL   | count == FIFO_DEPTH, pushes refused
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        MIDDLE = 2'd1,
        FULL   = 2'd2
    } fifo_ctrl_state_t;

    // Address width: at least one bit, even for tiny depths.
    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Counter width: must be able to hold the value FIFO_DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hwpe_stream_fifo_ctrl_occ_if.sv
// Handshake, storage-addressing and status bundle of the FIFO controller.
// The controller uses the slave modport; the surrounding stream logic uses master.
interface hwpe_stream_fifo_ctrl_occ_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int ADDR_W = hwpe_stream_fifo_ctrl_occ_pkg::addr_width(FIFO_DEPTH);

    logic                                             push_valid;
    logic                                             push_ready;
    logic                                             pop_valid;
    logic                                             pop_ready;
    logic                                             wr_en;
    logic [ADDR_W-1:0]                                wr_addr;
    logic [ADDR_W-1:0]                                rd_addr;
    logic                                             bypass;
    hwpe_stream_fifo_ctrl_occ_pkg::flags_fifo_occ_t   flags;

    modport slave (
        input  push_valid, pop_ready,
        output push_ready, pop_valid, wr_en, wr_addr, rd_addr, bypass, flags
    );

    modport master (
        output push_valid, pop_ready,
        input  push_ready, pop_valid, wr_en, wr_addr, rd_addr, bypass, flags
    );

endinterface

// File: rtl/hwpe_stream_wrap_counter.sv
// Modulo-N incrementer with enable and synchronous clear; wraps N-1 -> 0
// explicitly so N need not be a power of two.
module hwpe_stream_wrap_counter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next value: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hwpe_stream_fifo_ctrl_occ.sv
// FIFO control engine with occupancy counter and almost-full/empty flags for
// an external storage array of arbitrary depth.
// Optional empty-bypass build: define HWPE_STREAM_FIFO_CTRL_OCC_FALLTHROUGH_EN.
module hwpe_stream_fifo_ctrl_occ
    import hwpe_stream_fifo_ctrl_occ_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    hwpe_stream_fifo_ctrl_occ_if.slave  ctrl
);

    localparam int ADDR_W = addr_width(FIFO_DEPTH);
    localparam int CNT_W  = cnt_width(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_TH    = CNT_W'(ALMOST_EMPTY_TH);

    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("hwpe_stream_fifo_ctrl_occ: FIFO_DEPTH must be >= 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_chk_af
        $error("hwpe_stream_fifo_ctrl_occ: ALMOST_FULL_TH out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("hwpe_stream_fifo_ctrl_occ: ALMOST_EMPTY_TH out of range 0..FIFO_DEPTH-1");
    end

    fifo_ctrl_state_t  cs_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              illegal;
    logic              push_ready, pop_valid, bypass;
    logic              push, pop, push_st, pop_st;

    // Handshake decode from the registered state; bypass only in EMPTY.
    always_comb begin
        illegal    = 1'b0;
        push_ready = 1'b0;
        pop_valid  = 1'b0;
        bypass     = 1'b0;
        case (cs_q)
            EMPTY: begin
                push_ready = 1'b1;
`ifdef HWPE_STREAM_FIFO_CTRL_OCC_FALLTHROUGH_EN
                if (ctrl.push_valid) begin
                    pop_valid = 1'b1;
                    // Only a taken item bypasses; otherwise it is stored.
                    bypass    = ctrl.pop_ready;
                end
`endif
            end
            MIDDLE: begin
                push_ready = 1'b1;
                pop_valid  = 1'b1;
            end
            FULL: begin
                pop_valid  = 1'b1;
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
        push    = ctrl.push_valid & push_ready;
        pop     = pop_valid & ctrl.pop_ready;
        push_st = push & ~bypass;
        pop_st  = pop & ~bypass;
    end

    // Occupancy next value: unchanged on bypass or simultaneous push/pop.
    always_comb begin
        cnt_d = cnt_q;
        if (illegal) begin
            cnt_d = '0;
        end else if (push_st && !pop_st) begin
            cnt_d = cnt_q + ONE;
        end else if (pop_st && !push_st) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Control FSM and occupancy register; reset, then clear, override traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_q  <= EMPTY;
            cnt_q <= '0;
        end else if (clear_i) begin
            cs_q  <= EMPTY;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (cs_q)
                EMPTY: begin
                    if (push_st) cs_q <= (cnt_q == DEPTH_M1) ? FULL : MIDDLE;
                end
                MIDDLE: begin
                    if (push_st && !pop_st && cnt_q == DEPTH_M1) begin
                        cs_q <= FULL;
                    end else if (pop_st && !push_st && cnt_q == ONE) begin
                        cs_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop_st) cs_q <= MIDDLE;
                end
                default: begin
                    cs_q <= EMPTY;
                end
            endcase
        end
    end

    hwpe_stream_wrap_counter #(
        .N (FIFO_DEPTH),
        .W (ADDR_W)
    ) i_push_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i | illegal),
        .en_i    (push_st),
        .cnt_o   (wr_ptr)
    );

    hwpe_stream_wrap_counter #(
        .N (FIFO_DEPTH),
        .W (ADDR_W)
    ) i_pop_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i | illegal),
        .en_i    (pop_st),
        .cnt_o   (rd_ptr)
    );

    assign ctrl.push_ready = push_ready;
    assign ctrl.pop_valid  = pop_valid;
    assign ctrl.wr_en      = push_st;
    assign ctrl.wr_addr    = wr_ptr;
    assign ctrl.rd_addr    = rd_ptr;
    assign ctrl.bypass     = bypass;

    // Status derived from the registered count only.
    assign ctrl.flags.empty        = (cnt_q == '0);
    assign ctrl.flags.full         = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign ctrl.flags.almost_empty = (cnt_q <= AE_TH);
    assign ctrl.flags.almost_full  = (cnt_q >= AF_TH);
    assign ctrl.flags.count        = 16'(cnt_q);
    assign ctrl.flags.push_pointer = 16'(wr_ptr);
    assign ctrl.flags.pop_pointer  = 16'(rd_ptr);

endmodule

// File: tb/tb_hwpe_stream_fifo_ctrl_occ.sv
// Randomized bench for hwpe_stream_fifo_ctrl_occ against an occupancy/queue model.
module tb_hwpe_stream_fifo_ctrl_occ;
    import hwpe_stream_fifo_ctrl_occ_pkg::*;

    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int AW = addr_width(D);

    logic clk = 1'b0;
    logic rst, clr;
    always #5 clk = ~clk;

    hwpe_stream_fifo_ctrl_occ_if #(.FIFO_DEPTH(D)) bus ();

    hwpe_stream_fifo_ctrl_occ #(
        .FIFO_DEPTH      (D),
        .ALMOST_FULL_TH  (AF),
        .ALMOST_EMPTY_TH (AE)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .ctrl    (bus.slave)
    );

    int n_vec, n_err;
    bit chk_en;

    // Reference: occupancy, pointers, and the list of stored items in order.
    int          m_cnt, m_wp, m_rp;
    logic [31:0] q[$];
    logic [31:0] mem [D];
    logic [31:0] wdata;
    logic        e_pr, e_pv, e_byp, e_push, e_pop, e_wr;
    logic        s_wr;
    logic [AW-1:0] s_wa;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Apply inputs for one cycle and check every output mid-cycle.
    task automatic drive(input logic pv, input logic pr, input logic cl, input logic rs);
        bus.push_valid = pv;
        bus.pop_ready  = pr;
        clr            = cl;
        rst            = rs;
        wdata          = $urandom;
        #4;
        e_pr  = (m_cnt < D);
        e_pv  = (m_cnt > 0);
        e_byp = 1'b0;
`ifdef HWPE_STREAM_FIFO_CTRL_OCC_FALLTHROUGH_EN
        if (m_cnt == 0 && pv) begin
            e_pv  = 1'b1;
            e_byp = pr;
        end
`endif
        e_push = pv && e_pr;
        e_pop  = e_pv && pr;
        e_wr   = e_push && !e_byp;
        s_wr   = bus.wr_en;
        s_wa   = bus.wr_addr;
        if (chk_en) begin
            cmp("push_ready", 64'(bus.push_ready), 64'(e_pr));
            cmp("pop_valid", 64'(bus.pop_valid), 64'(e_pv));
            cmp("bypass", 64'(bus.bypass), 64'(e_byp));
            cmp("wr_en", 64'(bus.wr_en), 64'(e_wr));
            cmp("wr_addr", 64'(bus.wr_addr), 64'(m_wp));
            cmp("rd_addr", 64'(bus.rd_addr), 64'(m_rp));
            cmp("count", 64'(bus.flags.count), 64'(m_cnt));
            cmp("push_pointer", 64'(bus.flags.push_pointer), 64'(m_wp));
            cmp("pop_pointer", 64'(bus.flags.pop_pointer), 64'(m_rp));
            cmp("empty", 64'(bus.flags.empty), 64'(m_cnt == 0));
            cmp("full", 64'(bus.flags.full), 64'(m_cnt == D));
            cmp("almost_empty", 64'(bus.flags.almost_empty), 64'(m_cnt <= AE));
            cmp("almost_full", 64'(bus.flags.almost_full), 64'(m_cnt >= AF));
            if (e_pop && !e_byp && q.size() > 0)
                cmp("pop_data", 64'(mem[bus.rd_addr]), 64'(q[0]));
        end
    endtask

    // Advance through the clock edge: storage write and model update.
    task automatic finish_cycle();
        @(posedge clk);
        if (s_wr === 1'b1) mem[s_wa] = wdata;
        if (rst || clr) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
            q.delete();
        end else if (!e_byp) begin
            if (e_push) begin
                q.push_back(wdata);
                m_wp = (m_wp + 1) % D;
                m_cnt++;
            end
            if (e_pop) begin
                void'(q.pop_front());
                m_rp = (m_rp + 1) % D;
                m_cnt--;
            end
        end
        #1;
    endtask

    task automatic step(input logic pv, input logic pr, input logic cl, input logic rs);
        drive(pv, pr, cl, rs);
        finish_cycle();
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0;
        m_cnt = 0; m_wp = 0; m_rp = 0;
        foreach (mem[i]) mem[i] = '0;
        step(0, 0, 0, 1);
        chk_en = 1;

        // Reset state
        cmp("rst_count", 64'(bus.flags.count), 64'd0);
        cmp("rst_empty", 64'(bus.flags.empty), 64'd1);
        cmp("rst_almost_empty", 64'(bus.flags.almost_empty), 64'd1);
        cmp("rst_push_ready", 64'(bus.push_ready), 64'd1);
        cmp("rst_pop_valid", 64'(bus.pop_valid), 64'd0);

        // Fill without pops
        for (int i = 0; i < D; i++) begin
            cmp("fill_wr_addr", 64'(bus.wr_addr), 64'(i));
            step(1, 0, 0, 0);
        end
        cmp("fill_full", 64'(bus.flags.full), 64'd1);
        cmp("fill_push_ready", 64'(bus.push_ready), 64'd0);
        cmp("fill_count", 64'(bus.flags.count), 64'd5);
        step(1, 0, 0, 0);
        cmp("fill_6th_ignored", 64'(bus.flags.count), 64'd5);

        // Reset in the middle of a fill
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        cmp("midfill_count", 64'(bus.flags.count), 64'd3);
        step(1, 0, 0, 1);
        cmp("midrst_count", 64'(bus.flags.count), 64'd0);
        cmp("midrst_wr_addr", 64'(bus.wr_addr), 64'd0);
        cmp("midrst_rd_addr", 64'(bus.rd_addr), 64'd0);

        // Wrap: 7 pushes interleaved with 7 pops
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
        end
        cmp("wrap_count", 64'(bus.flags.count), 64'd0);
        cmp("wrap_empty", 64'(bus.flags.empty), 64'd1);
        cmp("wrap_wr_addr", 64'(bus.wr_addr), 64'd2);
        cmp("wrap_rd_addr", 64'(bus.rd_addr), 64'd2);

        // Simultaneous push/pop at count 3
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        cmp("sim_count", 64'(bus.flags.count), 64'd3);
        cmp("sim_wr_addr", 64'(bus.wr_addr), 64'd3);
        cmp("sim_rd_addr", 64'(bus.rd_addr), 64'd0);

        // Threshold ramp 0..5..0
        step(0, 0, 0, 1);
        for (int c = 0; c <= D; c++) begin
            cmp("ramp_up_af", 64'(bus.flags.almost_full), 64'(c == 4 || c == 5));
            cmp("ramp_up_ae", 64'(bus.flags.almost_empty), 64'(c == 0 || c == 1));
            if (c < D) step(1, 0, 0, 0);
        end
        for (int c = D; c > 0; c--) step(0, 1, 0, 0);
        cmp("ramp_down_empty", 64'(bus.flags.empty), 64'd1);

        // Clear overrides traffic
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        cmp("clear_count", 64'(bus.flags.count), 64'd0);
        cmp("clear_rd_addr", 64'(bus.rd_addr), 64'd0);

`ifdef HWPE_STREAM_FIFO_CTRL_OCC_FALLTHROUGH_EN
        step(0, 0, 0, 1);
        drive(1, 1, 0, 0);
        cmp("ft_bypass", 64'(bus.bypass), 64'd1);
        cmp("ft_wr_en", 64'(bus.wr_en), 64'd0);
        finish_cycle();
        cmp("ft_count", 64'(bus.flags.count), 64'd0);
        drive(1, 0, 0, 0);
        cmp("ft_store_wr_en", 64'(bus.wr_en), 64'd1);
        cmp("ft_store_bypass", 64'(bus.bypass), 64'd0);
        finish_cycle();
        cmp("ft_store_count", 64'(bus.flags.count), 64'd1);
`endif

        // Randomized traffic with alternating fill/drain bias
        for (int c = 0; c < 2000; c++) begin
            automatic int   bias = ((c / 150) % 2 == 0) ? 75 : 30;
            automatic logic pv   = ($urandom_range(0, 99) < bias);
            automatic logic pr   = ($urandom_range(0, 99) >= bias - 10);
            automatic logic cl   = ($urandom_range(0, 63) == 0);
            automatic logic rs   = ($urandom_range(0, 255) == 0);
            step(pv, pr, cl, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
